// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller with whole-line refill.
// Ports: clk/rst, cpu_req/addr/data/drdy, flush, mem_req/addr/ack/data, miss_cnt.
module icache_ctrl #(
    parameter int LINES      = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_data,
    output logic        cpu_drdy,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [15:0] miss_cnt
);

    localparam int WB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - 2 - WB - IB;
    localparam int HW = 30 - WB;
    localparam logic [WB-1:0] LAST_BEAT = WB'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, DONE} stateT;

    stateT state;
    stateT nextState;

    logic [LINES-1:0] validBits;
    logic [TW-1:0]    tagArr  [LINES];
    logic [31:0]      dataArr [LINES*LINE_WORDS];

    logic [WB-1:0] beat;
    logic [WB-1:0] nextBeat;
    logic          discard;
    // Upper address bits of the line being refilled (index + tag).
    logic [HW-1:0] lineHi;

    logic [WB-1:0] reqWord;
    logic [IB-1:0] reqIdx;
    logic [TW-1:0] reqTag;
    logic [IB-1:0] refIdx;
    logic [TW-1:0] refTag;
    logic          hit;
    logic          startMiss;
    logic          beatAck;
    logic          lastAck;

    assign reqWord  = cpu_addr[2 +: WB];
    assign reqIdx   = cpu_addr[2 + WB +: IB];
    assign reqTag   = cpu_addr[31 -: TW];
    assign refIdx   = lineHi[IB-1:0];
    assign refTag   = lineHi[IB +: TW];
    assign nextBeat = beat + 1'b1;

    assign hit = cpu_req && validBits[reqIdx] &&
                 (tagArr[reqIdx] == reqTag);

    assign beatAck = (state == REFILL) && mem_ack;

    always_comb begin
        nextState = state;
        cpu_drdy  = 1'b0;
        cpu_data  = '0;
        startMiss = 1'b0;
        lastAck   = 1'b0;
        unique case (state)
            IDLE: begin
                // A flush pulse blocks both the hit and any refill start.
                if (cpu_req && !flush) begin
                    if (hit) begin
                        cpu_drdy = 1'b1;
                        cpu_data = dataArr[{reqIdx, reqWord}];
                    end else begin
                        startMiss = 1'b1;
                        nextState = REFILL;
                    end
                end
            end
            REFILL: begin
                if (mem_ack && (beat == LAST_BEAT)) begin
                    lastAck   = 1'b1;
                    nextState = DONE;
                end
            end
            DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            validBits <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            miss_cnt  <= '0;
            discard   <= 1'b0;
            beat      <= '0;
            lineHi    <= '0;
        end else begin
            if (startMiss) begin
                lineHi            <= cpu_addr[31:2+WB];
                beat              <= '0;
                mem_addr          <= {cpu_addr[31:2+WB], WB'(0), 2'b00};
                mem_req           <= 1'b1;
                validBits[reqIdx] <= 1'b0;
                miss_cnt          <= miss_cnt + 16'd1;
            end
            if (beatAck) begin
                beat <= nextBeat;
                // Beat wraps, so the address folds back to the line base.
                mem_addr <= {lineHi, nextBeat, 2'b00};
                if (lastAck) begin
                    mem_req <= 1'b0;
                    if (!discard) begin
                        validBits[refIdx] <= 1'b1;
                    end
                end
            end
            // Flush overrides any validation happening on the same edge.
            if (flush) begin
                validBits <= '0;
                if (state != IDLE) begin
                    discard <= 1'b1;
                end
            end
            if (state == DONE) begin
                discard <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && beatAck) begin
            dataArr[{refIdx, beat}] <= mem_data;
            if (lastAck) begin
                tagArr[refIdx] <= refTag;
            end
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Randomised self-checking bench for icache_ctrl.
// Reference model tracks line contents abstractly and a backing-memory function.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_drdy;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [15:0] miss_cnt;

    int checks = 0;
    int errors = 0;

    int ackMode = 0;
    int ackCnt = 0;
    int reqCycles = 0;
    int nonZero = 0;
    logic [31:0] ackAddrs[$];

    bit mValid [16];
    int mTag   [16];
    int expMiss;

    icache_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_req  (cpu_req),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_drdy (cpu_drdy),
        .flush    (flush),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .miss_cnt (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0] + 16'h1234};
    endfunction

    task automatic checkEq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Backing memory: answers the registered request after each edge.
    always @(posedge clk) begin
        #2;
        mem_data = memWord(mem_addr);
        if (mem_req) begin
            case (ackMode)
                0: mem_ack = 1'b1;
                1: mem_ack = (ackCnt % 3 == 2);
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
            ackCnt++;
        end else begin
            mem_ack = 1'b0;
            ackCnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mem_req) begin
            reqCycles++;
            if (mem_ack) ackAddrs.push_back(mem_addr);
        end
        if (!cpu_drdy && cpu_data != 0) nonZero++;
    end

    task automatic waitDrdy(inout int lat, output logic [31:0] d);
        @(negedge clk);
        while (!cpu_drdy && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (!cpu_drdy) checkEq("drdy_timeout", 32'd0, 32'd1);
        d = cpu_data;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, output int lat,
                         output logic [31:0] d);
        cpu_addr = a;
        cpu_req = 1'b1;
        lat = 0;
        waitDrdy(lat, d);
    endtask

    int lat;
    logic [31:0] d;
    int m0;

    initial begin
        rst = 1'b1;
        cpu_req = 1'b0;
        cpu_addr = '0;
        flush = 1'b0;
        mem_ack = 1'b0;
        mem_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkEq("rst_mem_req", 32'(mem_req), 32'd0);
        checkEq("rst_mem_addr", mem_addr, 32'd0);
        checkEq("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        checkEq("rst_drdy", 32'(cpu_drdy), 32'd0);
        checkEq("rst_data", cpu_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss
        reqCycles = 0;
        ackAddrs.delete();
        fetch(32'h100, lat, d);
        checkEq("cold_lat", 32'(lat), 32'd6);
        checkEq("cold_data", d, memWord(32'h100));
        checkEq("cold_req_cycles", 32'(reqCycles), 32'd4);
        checkEq("cold_beats", 32'(ackAddrs.size()), 32'd4);
        for (int i = 0; i < 4 && i < ackAddrs.size(); i++)
            checkEq("cold_beat_addr", ackAddrs[i], 32'h100 + 32'(4 * i));
        checkEq("cold_miss_cnt", 32'(miss_cnt), 32'd1);

        // Back-to-back hits
        for (int i = 1; i < 4; i++) begin
            fetch(32'h100 + 32'(4 * i), lat, d);
            checkEq("hit_lat", 32'(lat), 32'd0);
            checkEq("hit_data", d, memWord(32'h100 + 32'(4 * i)));
        end
        checkEq("hit_miss_cnt", 32'(miss_cnt), 32'd1);

        // Conflict on index 0
        fetch(32'h200, lat, d);
        checkEq("conf1_lat", 32'(lat), 32'd6);
        checkEq("conf1_data", d, memWord(32'h200));
        fetch(32'h100, lat, d);
        checkEq("conf2_lat", 32'(lat), 32'd6);
        checkEq("conf_miss_cnt", 32'(miss_cnt), 32'd3);

        // Wait states: ack every third cycle
        ackMode = 1;
        ackAddrs.delete();
        fetch(32'h504, lat, d);
        checkEq("ws_lat", 32'(lat), 32'd14);
        checkEq("ws_data", d, memWord(32'h504));
        for (int i = 0; i < 4 && i < ackAddrs.size(); i++)
            checkEq("ws_beat_addr", ackAddrs[i], 32'h500 + 32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            fetch(32'h500 + 32'(4 * i), lat, d);
            checkEq("ws_hit_data", d, memWord(32'h500 + 32'(4 * i)));
        end
        ackMode = 0;

        // Flush during beat 2 of a refill
        m0 = int'(miss_cnt);
        cpu_addr = 32'h300;
        cpu_req = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        lat = 4;
        waitDrdy(lat, d);
        checkEq("fl_lat", 32'(lat), 32'd12);
        checkEq("fl_data", d, memWord(32'h300));
        checkEq("fl_miss_delta", 32'(int'(miss_cnt) - m0), 32'd2);
        fetch(32'h308, lat, d);
        checkEq("fl_hit_lat", 32'(lat), 32'd0);
        checkEq("fl_hit_data", d, memWord(32'h308));

        // Flush coinciding with a hit in IDLE
        cpu_addr = 32'h300;
        cpu_req = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        checkEq("flhit_drdy", 32'(cpu_drdy), 32'd0);
        checkEq("flhit_data", cpu_data, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        checkEq("flhit_no_refill", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        fetch(32'h300, lat, d);
        checkEq("flhit_remiss_lat", 32'(lat), 32'd6);

        // Reset in the middle of a refill
        cpu_addr = 32'h400;
        cpu_req = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkEq("mrst_mem_req", 32'(mem_req), 32'd0);
        checkEq("mrst_miss_cnt", 32'(miss_cnt), 32'd0);
        repeat (3) @(negedge clk);
        checkEq("mrst_idle", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        fetch(32'h300, lat, d);
        checkEq("mrst_lat", 32'(lat), 32'd6);
        checkEq("mrst_data", d, memWord(32'h300));
        checkEq("mrst_cnt", 32'(miss_cnt), 32'd1);

        // Random traffic against the line model
        for (int i = 0; i < 16; i++) begin
            mValid[i] = 1'b0;
            mTag[i] = 0;
        end
        mValid[0] = 1'b1;
        mTag[0] = 3;
        expMiss = 1;
        for (int n = 0; n < 60; n++) begin
            int t;
            int ix;
            int w;
            bit expHit;
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) begin
                flush = 1'b1;
                @(posedge clk);
                #1;
                flush = 1'b0;
                for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
            end
            ackMode = int'($urandom_range(0, 2));
            t = int'($urandom_range(0, 3));
            ix = int'($urandom_range(0, 3));
            w = int'($urandom_range(0, 3));
            a = 32'((t << 8) | (ix << 4) | (w << 2));
            expHit = mValid[ix] && (mTag[ix] == t);
            fetch(a, lat, d);
            if (!expHit) begin
                expMiss++;
                mValid[ix] = 1'b1;
                mTag[ix] = t;
            end
            checkEq("rnd_hit", 32'(lat == 0), 32'(expHit));
            checkEq("rnd_data", d, memWord(a));
            checkEq("rnd_miss_cnt", 32'(miss_cnt), 32'(expMiss));
        end

        checkEq("data_zero_when_idle", 32'(nonZero), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped instruction-cache controller between the CPU fetch port and a slower, word-wide instruction memory. Hits are served combinationally in the same cycle from register-based tag/data arrays. Misses run a refill state machine that fetches the whole line from backing memory, one word per handshake. It also provides whole-cache invalidation (fence.i) and a miss counter for performance debug.

## Interface
- `LINES`, 16: number of cache lines; power of two, ≥2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  fetch request; `cpu_addr` valid; held with stable address until `cpu_drdy`.
- `cpu_addr`  in  32  byte fetch address; bits [1:0] ignored.
- `cpu_data`  out  32  instruction word; 0 whenever `cpu_drdy`=0.
- `cpu_drdy`  out  1  `cpu_data` valid for `cpu_addr` this cycle.
- `flush`  in  1  single-cycle pulse: invalidate all lines.
- `mem_req`  out  1  backing-memory read request, held for the whole refill.
- `mem_addr`  out  32  word-aligned read address of current beat (registered).
- `mem_ack`  in  1  `mem_data` valid for `mem_addr`; one beat accepted per ack cycle.
- `mem_data`  in  32  read data.
- `miss_cnt`  out  16  number of misses since reset; wraps modulo 2^16.

## Operation
- Address split: word select = `cpu_addr[2 +: WB]` (WB = log2 LINE_WORDS). Index = next log2(LINES) bits. Tag = remaining upper bits. Defaults: word [3:2], index [7:4], tag [31:8].
- Storage: `valid[LINES]`, `tag[LINES]`, `data[LINES*LINE_WORDS]`, all flops. Only `valid` is reset.
- FSM states: IDLE, REFILL, DONE.
- IDLE:
  - hit = `cpu_req` & `valid[idx]` & `tag[idx]`==addr tag. On hit, `cpu_drdy`=1 and `cpu_data`=`data[idx][word]`, combinationally in the same cycle.
  - `cpu_req` & !hit & !`flush` → REFILL. On the transition: latch line base (addr with word+byte bits zeroed), clear beat counter, `mem_addr`←base, `mem_req`←1, `valid[idx]`←0, `miss_cnt`+1.
- REFILL:
  - On each `mem_ack`: `data[idx][beat]`←`mem_data`, beat+1, `mem_addr`+4.
  - On the ack of beat LINE_WORDS-1: `mem_req`←0, write `tag[idx]`, set `valid[idx]`←1 unless the discard flag is set, → DONE.
  - `cpu_drdy`=0 throughout.
- DONE: one bubble cycle, `cpu_drdy`=0, → IDLE. The held request then hits on the next cycle.
- Flush:
  - In IDLE: clears every `valid` bit next edge; `cpu_drdy`=0 that cycle; no refill starts that cycle.
  - In REFILL/DONE: clears every `valid` bit and sets the discard flag. The refill completes all beats on memory, but the line is not validated. The held request misses again and refills. Discard clears on entering IDLE.
- `cpu_req`=0: no lookup, `cpu_drdy`=0, no state change.
- `cpu_addr` changing during REFILL is a protocol violation. The refill continues to its latched line.

## Timing
- Reset values: state IDLE, all `valid`=0, `mem_req`=0, `mem_addr`=0, `miss_cnt`=0, `cpu_drdy`=0, `cpu_data`=0, discard=0, beat=0.
- Hit latency: 0 cycles (same-cycle `cpu_drdy`). Back-to-back hits are served every cycle.
- Miss latency, with the miss detected at cycle 0 and `mem_ack` tied high: `mem_req` is high in cycles 1..LINE_WORDS; DONE is cycle LINE_WORDS+1; `cpu_drdy` is at cycle LINE_WORDS+2 (6 for defaults). Each memory wait state adds 1 cycle.
- `mem_addr` and `mem_req` are registered; no combinational path from `cpu_*` to `mem_*`.
- Reset mid-refill: next edge returns to IDLE, `mem_req`=0, all lines invalid. Backing memory must tolerate the abandoned transaction. Any ack after reset is ignored.
- Simultaneous `flush` and a hit in IDLE: flush wins; `cpu_drdy`=0.
- Beat counter wraps to 0 after the last beat. `mem_addr` never crosses the line boundary.

## Test plan
- Cold miss, `mem_ack`=1: request 0x100 → `mem_req` high for 4 cycles, addresses 0x100, 0x104, 0x108, 0x10C; `cpu_drdy` at cycle 6 with the word from 0x100; `miss_cnt`=1.
- Hits after fill: 0x104, 0x108, 0x10C on consecutive cycles → `cpu_drdy`=1 each cycle with the stored words; `miss_cnt` stays 1.
- Conflict: 0x100 then 0x200 (same index 0, different tag) → second access misses and refills; re-access 0x100 misses again; `miss_cnt`=3.
- Wait states: `mem_ack` high every third cycle → 4 beats captured correctly; `cpu_drdy` at cycle 2+3·4.
- Flush during beat 2 of the refill for 0x300 → refill finishes, line not validated, second refill of 0x300 occurs, then a hit; `miss_cnt` increments by 2.
- `rst` pulsed mid-refill → next cycle `mem_req`=0, state IDLE; a subsequent request to a previously filled address misses.
